// File: rtl/window_3x3_gen.sv
// window_3x3_gen: streams a raster-order 8-bit image and emits one 3x3
// neighbourhood per pixel, in raster order of the centre pixel.
//   clk, rst                 clock, async active-high reset
//   start, cfg_width/height  frame start (IDLE only); size latched on accept
//   in_valid/in_ready/in_pixel   input pixel stream
//   out_valid/out_ready      output window handshake
//   w00..w22                 window taps, row-major, w11 = centre
//   out_border, out_row/col  centre lies on the image edge; centre coords
//   frame_done, cfg_err      one-cycle status pulses
// On border centres only w11 is meaningful; other taps may hold stale data.
module window_3x3_gen #(
  parameter int MAX_WIDTH  = 512,
  parameter int MAX_HEIGHT = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] cfg_width,
  input  logic [15:0] cfg_height,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_pixel,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  w00, w01, w02,
  output logic [7:0]  w10, w11, w12,
  output logic [7:0]  w20, w21, w22,
  output logic        out_border,
  output logic [15:0] out_row,
  output logic [15:0] out_col,
  output logic        frame_done,
  output logic        cfg_err
);
  localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam logic [15:0] MAXW = 16'(MAX_WIDTH);
  localparam logic [15:0] MAXH = 16'(MAX_HEIGHT);

  typedef enum logic [1:0] {IDLE, RUN, EOL, FLUSH} state_t;
  // one window column: top/middle/bottom rows
  typedef struct packed {
    logic [7:0] t;
    logic [7:0] m;
    logic [7:0] b;
  } col_t;

  state_t      state_q, state_d;
  logic [15:0] wid, hgt;
  logic [15:0] in_row, in_col;   // next expected input pixel (col reused as FLUSH column)
  logic        flush_end;        // last FLUSH centre has been presented
  col_t [2:0]  win;              // win[0] = left column

  // lb0 holds the previous row, lb1 the one before it
  logic [7:0]  lb0 [MAX_WIDTH];
  logic [7:0]  lb1 [MAX_WIDTH];
  logic [AW-1:0] lb_idx;
  logic [7:0]  rd0, rd1;

  logic slot_free, in_fire, cfg_ok, last_col, emit;

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = (state_q == RUN) && slot_free;
  assign in_fire   = in_valid && in_ready;
  assign cfg_ok    = (cfg_width >= 16'd3) && (cfg_width <= MAXW) &&
                     (cfg_height >= 16'd3) && (cfg_height <= MAXH);
  assign last_col  = (in_col == wid - 16'd1);
  assign emit      = (in_row != 16'd0) && (in_col != 16'd0);
  assign lb_idx    = in_col[AW-1:0];
  assign rd0       = lb0[lb_idx];
  assign rd1       = lb1[lb_idx];

  assign {w00, w01, w02} = {win[0].t, win[1].t, win[2].t};
  assign {w10, w11, w12} = {win[0].m, win[1].m, win[2].m};
  assign {w20, w21, w22} = {win[0].b, win[1].b, win[2].b};

  function automatic logic is_border(input logic [15:0] r, c, h, w);
    return (r == 16'd0) || (r == h - 16'd1) || (c == 16'd0) || (c == w - 16'd1);
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start && cfg_ok) state_d = RUN;
      RUN:   if (in_fire && last_col && in_row != 16'd0) state_d = EOL;
      // out_row still holds the row of the centre being finished
      EOL:   if (slot_free) state_d = (out_row == hgt - 16'd2) ? FLUSH : RUN;
      FLUSH: if (slot_free && flush_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wid <= '0; hgt <= '0; in_row <= '0; in_col <= '0; flush_end <= 1'b0;
      win <= '0; out_valid <= 1'b0; out_border <= 1'b0;
      out_row <= '0; out_col <= '0; frame_done <= 1'b0; cfg_err <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          if (cfg_ok) begin
            wid <= cfg_width; hgt <= cfg_height;
            in_row <= '0; in_col <= '0; flush_end <= 1'b0;
          end else cfg_err <= 1'b1;
        end
        RUN: begin
          if (in_fire) begin
            win[0] <= win[1];
            win[1] <= win[2];
            win[2] <= col_t'{rd1, rd0, in_pixel};
            out_valid <= emit;
            if (emit) begin
              out_row    <= in_row - 16'd1;
              out_col    <= in_col - 16'd1;
              out_border <= is_border(in_row - 16'd1, in_col - 16'd1, hgt, wid);
            end
            if (last_col) begin
              in_col <= '0;
              in_row <= (in_row == hgt - 16'd1) ? 16'd0 : in_row + 16'd1;
            end else in_col <= in_col + 16'd1;
          end else if (out_ready) out_valid <= 1'b0;
        end
        EOL: if (slot_free) begin
          // shift in a dummy right column so the last column becomes the centre
          win[0] <= win[1];
          win[1] <= win[2];
          win[2] <= '0;
          out_valid  <= 1'b1;
          out_col    <= out_col + 16'd1;
          out_border <= 1'b1;
        end
        FLUSH: if (slot_free) begin
          if (flush_end) begin
            out_valid  <= 1'b0;
            frame_done <= 1'b1;
          end else begin
            // last row sits in lb0; every centre here is on the bottom border
            win[0] <= win[1];
            win[1] <= col_t'{rd1, rd0, 8'd0};
            win[2] <= '0;
            out_valid  <= 1'b1;
            out_row    <= hgt - 16'd1;
            out_col    <= in_col;
            out_border <= 1'b1;
            if (last_col) flush_end <= 1'b1;
            else          in_col <= in_col + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // line buffers carry no reset; stale entries only feed border centres
  always_ff @(posedge clk) begin
    if (in_fire) begin
      lb0[lb_idx] <= in_pixel;
      lb1[lb_idx] <= rd0;
    end
  end
endmodule
